uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with an integrated first-word-fall-through receive FIFO: the next generation of the board's fixed 8N1 echo path. It adds configurable data width, baud divisor, parity and stop bits, start-bit glitch rejection, sticky error flags and a valid/ready read side. It sits between the `rx` pin and the user logic on the Colorlight design, all in the `dev_clk` domain.

## Interface
- `CLKS_PER_BIT`, 16: `dev_clk` cycles per UART bit; even, ≥ 4.
- `DATA_BITS`, 8: payload bits per frame, 5–9, LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: entries; power of two, ≥ 2.

- `dev_clk  in  1`: sole clock, rising edge.
- `rst_n  in  1`: reset, synchronous, active-low.
- `rx  in  1`: asynchronous serial input, idle high.
- `m_data  out  DATA_BITS`: FIFO head word.
- `m_valid  out  1`: FIFO not empty.
- `m_ready  in  1`: pops the head when `m_valid` is high.
- `fifo_count  out  $clog2(FIFO_DEPTH)+1`: occupancy.
- `frame_err  out  1`: sticky; a stop bit was sampled low.
- `parity_err  out  1`: sticky; a parity mismatch occurred.
- `overflow  out  1`: sticky; a good frame was dropped because the FIFO was full.
- `clr_err  in  1`: clears all three sticky flags.

## Operation
- **Input synchroniser.** Two flops on `rx`, both reset to 1. Start-edge detect fires on synchronised `rx` going 1→0.
- **FSM states.** IDLE, START, DATA, PARITY, STOP. One bit counter and one clock counter, each `$clog2` wide.
- **IDLE → START** on a start edge. The clock counter is cleared.
- **START.** At count `CLKS_PER_BIT/2-1` (mid-bit), sample the line:
  - line still 0: go to DATA;
  - line 1: glitch, return to IDLE with no flags set.
- **DATA.** Sample every `CLKS_PER_BIT` cycles into a shift register, LSB first. After `DATA_BITS` samples go to PARITY if `PARITY≠0`, otherwise to STOP.
- **PARITY.** Sample once and compare against the XOR of the data bits (inverted for odd parity). Record any mismatch.
- **STOP.** Sample `STOP_BITS` times. Any 0 sets `frame_err`. After the last sample, return to IDLE in the same cycle, ready for a back-to-back start.
- **Push rule.** A frame is pushed only if it has neither a parity error nor a framing error.
  - Errored frames are discarded and set the matching flag.
  - A good frame arriving while the FIFO is full (and no pop in that cycle) is dropped and sets `overflow`.
- **Push and pop in the same cycle.**
  - When full: both take effect and the count is unchanged.
  - When empty: the push wins; `m_valid` rises next cycle and the pop is ignored because `m_valid` was 0.
- **Flag set vs clear.** If `clr_err` and a flag-set event occur in the same cycle, the set wins.
- **FIFO.** Circular buffer with `$clog2(FIFO_DEPTH)`-bit pointers that wrap naturally. `m_data` is valid whenever `m_valid=1`.
- **Reset values.** `m_valid=0`, `fifo_count=0`, all flags 0, `m_data=0`, FSM in IDLE, pointers 0. Reset in the middle of a frame abandons the frame; reception resumes at the next start edge after `rst_n` rises.

## Timing
- `rx` pin to synchronised line: 2 cycles.
- Take cycle 0 as the start-edge detect cycle, with C = `CLKS_PER_BIT`, N = `DATA_BITS`, P = 1 if parity is enabled (else 0):
  - start sample at cycle C/2−1;
  - data bit k sample at C/2−1+(k+1)·C;
  - last stop sample at C/2−1+(N+P+STOP_BITS)·C.
- Push happens on the cycle after the last stop sample, and `m_valid` is high on the cycle after that push edge.
- Example, 8N1 with C=16: last stop sample at cycle 151, `m_valid` high at 152.
- Pop: `m_valid && m_ready` at edge t. New head or `m_valid=0` appears at t+1.
- `fifo_count` updates on the same edge as each push or pop.

## Structure
- Package `uart_pkg`:
  - parity constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - FSM state encoding.
- Sub-module `sync_fifo`: parameters WIDTH and DEPTH; push, pop, full and empty signals, `count`; FWFT read side. It is instantiated once; the receiver FSM stays in `uart_rx_fifo`.

## Test plan
- **Back-to-back frames.** Defaults; drive 'w' (0x77) then 'r' (0x72) at 16 cycles/bit with `m_ready=0` → `fifo_count=2`. Raise `m_ready` → `m_data` is 0x77 then 0x72, then `m_valid=0` and all flags 0.
- **Glitch.** `rx` low for 4 cycles, then high → FSM returns to IDLE, `fifo_count=0`, no flags set.
- **Framing error.** 0x55 with the stop bit driven 0 → `frame_err=1` and nothing pushed. One cycle of `clr_err` → flag 0. A following good 0x55 is received.
- **Parity.** `PARITY=2`, 0x77 (six 1s) with parity bit 1 → `parity_err=1`, dropped. Resend with parity 0 → 0x77 delivered.
- **Overflow.** `FIFO_DEPTH=4`, five frames 0x01..0x05 with `m_ready=0` → `fifo_count=4`, `overflow=1`. Draining yields 0x01..0x04.
- **Reset mid-frame.** Assert `rst_n=0` during data bit 3 → all outputs at their reset values next edge. A subsequent full 0x72 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART receive path.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with a first-word-fall-through read side.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CntW'(DEPTH));
    do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    do_push = push & (~full | do_pop);
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver (data width, parity, stop bits) feeding an FWFT receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          dev_clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  input  logic                          clr_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] HalfM1   = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullM1   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastData = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

  rx_state_e            state_q;
  logic                 rx_meta_q, rx_line_q, rx_prev_q;
  logic [CntW-1:0]      clk_cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bad_q, frm_bad_q;

  logic start_edge, bit_tick, frame_done, stop_bad, good_frame, ovf_set, par_exp;
  logic fifo_full, fifo_empty;

  always_comb begin
    start_edge = rx_prev_q & ~rx_line_q;
    bit_tick   = (clk_cnt_q == FullM1);
    frame_done = (state_q == StStop) && bit_tick && (bit_cnt_q == LastStop);
    stop_bad   = frm_bad_q | ~rx_line_q;
    good_frame = frame_done & ~stop_bad & ~par_bad_q;
    m_valid    = ~fifo_empty;
    ovf_set    = good_frame & fifo_full & ~(m_valid & m_ready);
    par_exp    = (^shift_q) ^ (PARITY == PAR_ODD);
  end

  always_ff @(posedge dev_clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_line_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_line_q <= rx_meta_q;
      rx_prev_q <= rx_line_q;
    end
  end

  always_ff @(posedge dev_clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      frm_bad_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          clk_cnt_q <= '0;
          // The edge-detect cycle is the first cycle of the start bit.
          if (start_edge) begin
            state_q   <= StStart;
            clk_cnt_q <= CntW'(1);
          end
        end
        StStart: begin
          if (clk_cnt_q == HalfM1) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            par_bad_q <= 1'b0;
            frm_bad_q <= 1'b0;
            state_q   <= rx_line_q ? StIdle : StData;
          end else begin
            clk_cnt_q <= clk_cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (bit_tick) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_line_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LastData) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY != PAR_NONE) ? StParity : StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CntW'(1);
          end
        end
        StParity: begin
          if (bit_tick) begin
            clk_cnt_q <= '0;
            par_bad_q <= (rx_line_q != par_exp);
            state_q   <= StStop;
          end else begin
            clk_cnt_q <= clk_cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (bit_tick) begin
            clk_cnt_q <= '0;
            if (!rx_line_q) frm_bad_q <= 1'b1;
            if (bit_cnt_q == LastStop) begin
              bit_cnt_q <= '0;
              state_q   <= StIdle;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as clr_err wins.
  always_ff @(posedge dev_clk) begin
    if (!rst_n) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err  <= (frame_err  & ~clr_err) | (frame_done & stop_bad);
      parity_err <= (parity_err & ~clr_err) | (frame_done & par_bad_q);
      overflow   <= (overflow   & ~clr_err) | ovf_set;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (dev_clk),
    .rst_n   (rst_n),
    .push    (good_frame),
    .wr_data (shift_q),
    .pop     (m_ready),
    .rd_data (m_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: two instances (8N1 depth 16, 8E2 depth 4 at 8 clocks/bit) against a queue model.
module tb_uart_rx_fifo;

  localparam int C0 = 16;
  localparam int D0 = 16;
  localparam int C1 = 8;
  localparam int D1 = 4;
  localparam int NB = 8;

  logic       dev_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [1:0] rx      = 2'b11;
  logic [1:0] rdy     = 2'b00;
  logic [1:0] clr     = 2'b00;

  logic [7:0] md0, md1;
  logic       mv0, mv1;
  logic [4:0] fc0;
  logic [2:0] fc1;
  logic       fe0, pe0, ov0, fe1, pe1, ov1;

  uart_rx_fifo u_dut0 (
    .dev_clk    (dev_clk),
    .rst_n      (rst_n),
    .rx         (rx[0]),
    .m_data     (md0),
    .m_valid    (mv0),
    .m_ready    (rdy[0]),
    .fifo_count (fc0),
    .frame_err  (fe0),
    .parity_err (pe0),
    .overflow   (ov0),
    .clr_err    (clr[0])
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT (C1),
    .DATA_BITS    (NB),
    .PARITY       (2),
    .STOP_BITS    (2),
    .FIFO_DEPTH   (D1)
  ) u_dut1 (
    .dev_clk    (dev_clk),
    .rst_n      (rst_n),
    .rx         (rx[1]),
    .m_data     (md1),
    .m_valid    (mv1),
    .m_ready    (rdy[1]),
    .fifo_count (fc1),
    .frame_err  (fe1),
    .parity_err (pe1),
    .overflow   (ov1),
    .clr_err    (clr[1])
  );

  always #5 dev_clk = ~dev_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per-instance FIFO contents, sticky flags and one pending end-of-frame event.
  int         cyc = 0;
  logic [7:0] mmem [2][16];
  int         mhead [2];
  int         mcnt  [2];
  logic       mfe [2], mpe [2], mov [2];
  logic       ev_on [2];
  int         ev_cyc [2];
  logic [7:0] ev_data [2];
  logic       ev_par [2], ev_frm [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      mhead[i] = 0; mcnt[i] = 0; mfe[i] = 0; mpe[i] = 0; mov[i] = 0; ev_on[i] = 0;
    end
  end

  always @(posedge dev_clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      int   dep;
      logic pop, fire, good, os;
      dep = (i == 0) ? D0 : D1;
      if (!rst_n) begin
        mhead[i] = 0; mcnt[i] = 0; mfe[i] = 0; mpe[i] = 0; mov[i] = 0; ev_on[i] = 0;
      end else begin
        pop  = rdy[i] && (mcnt[i] > 0);
        fire = ev_on[i] && (ev_cyc[i] == cyc);
        good = fire && !ev_par[i] && !ev_frm[i];
        os   = good && (mcnt[i] == dep) && !pop;
        mfe[i] = (mfe[i] && !clr[i]) || (fire && ev_frm[i]);
        mpe[i] = (mpe[i] && !clr[i]) || (fire && ev_par[i]);
        mov[i] = (mov[i] && !clr[i]) || os;
        if (pop) begin
          mhead[i] = (mhead[i] + 1) % dep;
          mcnt[i]  = mcnt[i] - 1;
        end
        if (good && !os) begin
          mmem[i][(mhead[i] + mcnt[i]) % dep] = ev_data[i];
          mcnt[i] = mcnt[i] + 1;
        end
        if (fire) ev_on[i] = 1'b0;
      end
    end
  end

  always @(negedge dev_clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] exp_d;
        exp_d = (mcnt[i] > 0) ? mmem[i][mhead[i]] : 8'h00;
        if (i == 0) begin
          check("i0_m_valid", 32'(mv0), 32'(mcnt[0] > 0));
          check("i0_fifo_count", 32'(fc0), 32'(mcnt[0]));
          check("i0_m_data", 32'(md0), 32'(exp_d));
          check("i0_flags", 32'({fe0, pe0, ov0}), 32'({mfe[0], mpe[0], mov[0]}));
        end else begin
          check("i1_m_valid", 32'(mv1), 32'(mcnt[1] > 0));
          check("i1_fifo_count", 32'(fc1), 32'(mcnt[1]));
          check("i1_m_data", 32'(md1), 32'(exp_d));
          check("i1_flags", 32'({fe1, pe1, ov1}), 32'({mfe[1], mpe[1], mov[1]}));
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge dev_clk);
    #1;
  endtask

  // Sends one frame on instance i; par_flip inverts the correct even-parity bit.
  task automatic send_frame(input int i, input logic [7:0] d, input logic par_flip,
                            input logic stop_val);
    int c, p, s;
    c = (i == 0) ? C0 : C1;
    p = (i == 0) ? 0 : 1;
    s = (i == 0) ? 1 : 2;
    ev_cyc[i]  = cyc + 2 + c / 2 + (NB + p + s) * c;
    ev_data[i] = d;
    ev_par[i]  = par_flip;
    ev_frm[i]  = !stop_val;
    ev_on[i]   = 1'b1;
    rx[i] = 1'b0;
    hold(c);
    for (int b = 0; b < NB; b++) begin
      rx[i] = d[b];
      hold(c);
    end
    if (p == 1) begin
      rx[i] = (^d) ^ par_flip;
      hold(c);
    end
    for (int b = 0; b < s; b++) begin
      rx[i] = stop_val;
      hold(c);
    end
    rx[i] = 1'b1;
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    hold(3);
    check("reset_m_valid", 32'(mv0), 32'd0);
    check("reset_fifo_count", 32'(fc0), 32'd0);
    check("reset_m_data", 32'(md0), 32'd0);
    rst_n = 1'b1;
    hold(4);

    // Back-to-back 'w' then 'r', then drain.
    send_frame(0, 8'h77, 1'b0, 1'b1);
    send_frame(0, 8'h72, 1'b0, 1'b1);
    hold(C0);
    check("b2b_count", 32'(fc0), 32'd2);
    check("b2b_head0", 32'(md0), 32'h77);
    rdy[0] = 1'b1;
    hold(1);
    check("b2b_head1", 32'(md0), 32'h72);
    hold(1);
    check("b2b_empty", 32'(mv0), 32'd0);
    check("b2b_flags", 32'({fe0, pe0, ov0}), 32'd0);
    rdy[0] = 1'b0;

    // Short low pulse is rejected as a glitch.
    rx[0] = 1'b0;
    hold(4);
    rx[0] = 1'b1;
    hold(3 * C0);
    check("glitch_count", 32'(fc0), 32'd0);
    check("glitch_flags", 32'({fe0, pe0, ov0}), 32'd0);

    // Framing error, clear, then a good frame.
    send_frame(0, 8'h55, 1'b0, 1'b0);
    hold(4);
    check("frm_flag", 32'(fe0), 32'd1);
    check("frm_dropped", 32'(fc0), 32'd0);
    clr[0] = 1'b1;
    hold(1);
    clr[0] = 1'b0;
    check("frm_cleared", 32'(fe0), 32'd0);
    send_frame(0, 8'h55, 1'b0, 1'b1);
    hold(2);
    check("frm_good_count", 32'(fc0), 32'd1);
    check("frm_good_data", 32'(md0), 32'h55);

    // Even parity: 0x77 with parity bit 1 is rejected, with 0 is delivered.
    send_frame(1, 8'h77, 1'b1, 1'b1);
    hold(2);
    check("par_flag", 32'(pe1), 32'd1);
    check("par_dropped", 32'(fc1), 32'd0);
    clr[1] = 1'b1;
    hold(1);
    clr[1] = 1'b0;
    send_frame(1, 8'h77, 1'b0, 1'b1);
    hold(2);
    check("par_good_data", 32'(md1), 32'h77);
    check("par_flag_clear", 32'(pe1), 32'd0);
    rdy[1] = 1'b1;
    hold(1);
    rdy[1] = 1'b0;

    // Overflow of the depth-4 instance.
    for (int k = 1; k <= 5; k++) send_frame(1, 8'(k), 1'b0, 1'b1);
    hold(2);
    check("ovf_count", 32'(fc1), 32'd4);
    check("ovf_flag", 32'(ov1), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      check("ovf_drain", 32'(md1), 32'(k));
      rdy[1] = 1'b1;
      hold(1);
      rdy[1] = 1'b0;
    end
    check("ovf_empty", 32'(mv1), 32'd0);

    // Reset during data bit 3 with data queued and a flag set.
    send_frame(0, 8'h55, 1'b0, 1'b0);
    hold(4);
    d = 8'h72;
    rx[0] = 1'b0;
    hold(C0);
    for (int b = 0; b < 3; b++) begin
      rx[0] = d[b];
      hold(C0);
    end
    rx[0] = d[3];
    hold(C0 / 2);
    rst_n = 1'b0;
    rx = 2'b11;
    hold(1);
    check("rst_m_valid", 32'(mv0), 32'd0);
    check("rst_count", 32'(fc0), 32'd0);
    check("rst_m_data", 32'(md0), 32'd0);
    check("rst_flags0", 32'({fe0, pe0, ov0}), 32'd0);
    check("rst_flags1", 32'({fe1, pe1, ov1}), 32'd0);
    hold(4);
    rst_n = 1'b1;
    hold(4);
    send_frame(0, 8'h72, 1'b0, 1'b1);
    hold(2);
    check("post_rst_count", 32'(fc0), 32'd1);
    check("post_rst_data", 32'(md0), 32'h72);
    hold(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
